wb_pipe: RTL and testbench

WB_PIPE -- requirements
Module: wb_pipe

---
 rtl/wb_pipe.sv | 158 +++++++++++++++
 tb/tb_wb_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe.sv
// Write-back pipeline register with syscall halt FSM, load alignment/extension
// and a retired-instruction counter.
module wb_pipe #(
    parameter  int DATA_W = 32,
    parameter  int REG_AW = 5,
    parameter  int CNT_W  = 32,
    localparam int AL_W   = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              validm,
    input  logic              regwritem,
    input  logic              memtoregm,
    input  logic              jumplinkm,
    input  logic              syscallm,
    input  logic              ldsignm,
    input  logic [1:0]        ldsizem,
    input  logic [AL_W-1:0]   addrlom,
    input  logic [DATA_W-1:0] rdm,
    input  logic [DATA_W-1:0] aluoutm,
    input  logic [DATA_W-1:0] pcplus4m,
    input  logic [REG_AW-1:0] writeregm,
    input  logic              resume,
    output logic              validw,
    output logic              regwrite,
    output logic [REG_AW-1:0] writereg,
    output logic [DATA_W-1:0] result,
    output logic              halt,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              regwritew, memtoregw, jumplinkw, syscallw, ldsignw;
    logic [1:0]        ldsizew;
    logic [AL_W-1:0]   addrlow;
    logic [DATA_W-1:0] rdw, aluoutw, pcplus4w;

    logic hold;
    logic resume_edge;

    assign resume_edge = (state_q == HALT) && resume;
    assign hold        = stall || ((state_q == HALT) && !resume);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt once a valid syscall sits in WB; only resume leaves HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (validw && syscallw) state_d = HALT;
            HALT:    if (resume)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validw    <= 1'b0;
            regwritew <= 1'b0;
            memtoregw <= 1'b0;
            jumplinkw <= 1'b0;
            syscallw  <= 1'b0;
            ldsignw   <= 1'b0;
            ldsizew   <= 2'b00;
            addrlow   <= '0;
            rdw       <= '0;
            aluoutw   <= '0;
            pcplus4w  <= '0;
            writereg  <= '0;
            retired   <= '0;
        end else if (flush) begin
            validw    <= 1'b0;
            regwritew <= 1'b0;
            memtoregw <= 1'b0;
            jumplinkw <= 1'b0;
            syscallw  <= 1'b0;
            ldsignw   <= 1'b0;
        end else if (hold) begin
            // A resume under stall still retires the pending syscall.
            if (resume_edge) begin
                syscallw <= 1'b0;
            end
        end else begin
            validw    <= validm;
            regwritew <= regwritem;
            memtoregw <= memtoregm;
            jumplinkw <= jumplinkm;
            syscallw  <= syscallm;
            ldsignw   <= ldsignm;
            ldsizew   <= ldsizem;
            addrlow   <= addrlom;
            rdw       <= rdm;
            aluoutw   <= aluoutm;
            pcplus4w  <= pcplus4m;
            writereg  <= writeregm;
            if (validm) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Little-endian lane selection; shift amounts are in bits.
    logic [AL_W+2:0] bsh, hsh, wsh;
    logic [7:0]      ldbyte;
    logic [15:0]     ldhalf;
    logic [31:0]     ldword;
    logic [DATA_W-1:0] loaddata;

    assign bsh    = {addrlow, 3'b000};
    assign hsh    = {addrlow[AL_W-1:1], 4'b0000};
    assign wsh    = (AL_W+3)'(addrlow >> 2) << 5;
    assign ldbyte = 8'(rdw >> bsh);
    assign ldhalf = 16'(rdw >> hsh);
    assign ldword = 32'(rdw >> wsh);

    always_comb begin
        loaddata = rdw;
        case (ldsizew)
            2'b10: begin
                loaddata = DATA_W'(ldbyte);
                if (ldsignw && ldbyte[7]) loaddata = loaddata | ~DATA_W'(8'hFF);
            end
            2'b01: begin
                loaddata = DATA_W'(ldhalf);
                if (ldsignw && ldhalf[15]) loaddata = loaddata | ~DATA_W'(16'hFFFF);
            end
            2'b00: begin
                loaddata = DATA_W'(ldword);
                if (ldsignw && ldword[31]) loaddata = loaddata | ~DATA_W'(32'hFFFF_FFFF);
            end
            default: loaddata = rdw;
        endcase
    end

    always_comb begin
        if (jumplinkw)      result = pcplus4w;
        else if (memtoregw) result = loaddata;
        else                result = aluoutw;
    end

    assign halt     = (state_q == HALT);
    assign regwrite = validw && regwritew && (state_q == RUN) && (writereg != '0);

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: directed vector table, syscall/reset/wrap
// sequences, then randomized traffic against a behavioural model.
module tb_wb_pipe;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst, stall, flush, validm, regwritem, memtoregm;
    logic            jumplinkm, syscallm, ldsignm, resume;
    logic [1:0]      ldsizem;
    logic [1:0]      addrlom;
    logic [DW-1:0]   rdm, aluoutm, pcplus4m;
    logic [RAW-1:0]  writeregm;
    logic            validw, regwrite, halt;
    logic [RAW-1:0]  writereg;
    logic [DW-1:0]   result;
    logic [CW-1:0]   retired;

    wb_pipe #(.DATA_W(DW), .REG_AW(RAW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validm(validm),
        .regwritem(regwritem), .memtoregm(memtoregm), .jumplinkm(jumplinkm),
        .syscallm(syscallm), .ldsignm(ldsignm), .ldsizem(ldsizem),
        .addrlom(addrlom), .rdm(rdm), .aluoutm(aluoutm), .pcplus4m(pcplus4m),
        .writeregm(writeregm), .resume(resume), .validw(validw),
        .regwrite(regwrite), .writereg(writereg), .result(result),
        .halt(halt), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stall, flush, validm, regwritem, memtoregm;
        logic        jumplinkm, syscallm, ldsignm;
        logic [1:0]  ldsizem;
        logic [1:0]  addrlom;
        logic [31:0] rdm, aluoutm, pcplus4m;
        logic [4:0]  writeregm;
        logic        resume;
    } stim_t;

    typedef struct packed {
        logic        validw, regwrite;
        logic [4:0]  writereg;
        logic [31:0] result;
        logic        halt;
        logic [3:0]  retired;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    int passCount  = 0;
    int totalCount = 0;

    // Reference model: the WB contents as the rules describe them.
    logic        m_valid, m_regwr, m_mem, m_jl, m_sys, m_sign, m_halted;
    logic [1:0]  m_size, m_addr;
    logic [31:0] m_rd, m_alu, m_pc;
    logic [4:0]  m_wreg;
    int          m_retired;

    task automatic modelEdge(input stim_t s);
        logic nextHalted;
        if (s.rst) begin
            {m_valid, m_regwr, m_mem, m_jl, m_sys, m_sign, m_halted} = '0;
            m_size = 0; m_addr = 0; m_rd = 0; m_alu = 0; m_pc = 0; m_wreg = 0;
            m_retired = 0;
        end else begin
            nextHalted = m_halted ? !s.resume : (m_valid && m_sys);
            if (s.flush) begin
                {m_valid, m_regwr, m_mem, m_jl, m_sys, m_sign} = '0;
            end else if (s.stall || (m_halted && !s.resume)) begin
                if (m_halted && s.resume) m_sys = 1'b0;
            end else begin
                m_valid = s.validm;    m_regwr = s.regwritem; m_mem = s.memtoregm;
                m_jl    = s.jumplinkm; m_sys   = s.syscallm;  m_sign = s.ldsignm;
                m_size  = s.ldsizem;   m_addr  = s.addrlom;   m_rd  = s.rdm;
                m_alu   = s.aluoutm;   m_pc    = s.pcplus4m;  m_wreg = s.writeregm;
                if (s.validm) m_retired = (m_retired + 1) % 16;
            end
            m_halted = nextHalted;
        end
    endtask

    function automatic logic [31:0] modelLoad();
        logic [31:0] v;
        case (m_size)
            2'b10: begin
                v = (m_rd >> (8 * m_addr)) & 32'hFF;
                if (m_sign && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (m_rd >> (16 * (m_addr / 2))) & 32'hFFFF;
                if (m_sign && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = m_rd;
        endcase
        return v;
    endfunction

    function automatic exp_t modelExpect();
        exp_t e;
        e.validw   = m_valid;
        e.regwrite = m_valid && m_regwr && !m_halted && (m_wreg != 0);
        e.writereg = m_wreg;
        e.result   = m_jl ? m_pc : (m_mem ? modelLoad() : m_alu);
        e.halt     = m_halted;
        e.retired  = 4'(m_retired);
        return e;
    endfunction

    function automatic exp_t mkExp(input logic v, input logic rw, input logic [4:0] wr,
                                   input logic [31:0] res, input logic h,
                                   input logic [3:0] ret);
        exp_t e;
        e.validw = v; e.regwrite = rw; e.writereg = wr;
        e.result = res; e.halt = h; e.retired = ret;
        return e;
    endfunction

    function automatic stim_t aluOp(input logic [4:0] wr, input logic [31:0] alu);
        stim_t s;
        s = '0;
        s.validm = 1'b1; s.regwritem = 1'b1; s.writeregm = wr; s.aluoutm = alu;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst = s.rst; stall = s.stall; flush = s.flush; validm = s.validm;
        regwritem = s.regwritem; memtoregm = s.memtoregm; jumplinkm = s.jumplinkm;
        syscallm = s.syscallm; ldsignm = s.ldsignm; ldsizem = s.ldsizem;
        addrlom = s.addrlom; rdm = s.rdm; aluoutm = s.aluoutm;
        pcplus4m = s.pcplus4m; writeregm = s.writeregm; resume = s.resume;
        @(posedge clk);
        modelEdge(s);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [31:0] got, input logic [31:0] want);
        totalCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Data fields are only meaningful while WB holds a valid instruction.
    task automatic checkOutput(input string name, input exp_t e);
        checkOne({name, ".validw"},   32'(validw),   32'(e.validw));
        checkOne({name, ".regwrite"}, 32'(regwrite), 32'(e.regwrite));
        checkOne({name, ".halt"},     32'(halt),     32'(e.halt));
        checkOne({name, ".retired"},  32'(retired),  32'(e.retired));
        if (e.validw) begin
            checkOne({name, ".writereg"}, 32'(writereg), 32'(e.writereg));
            checkOne({name, ".result"},   result,        e.result);
        end
    endtask

    task automatic step(input string name, input stim_t s, input exp_t e);
        applyStimulus(s);
        checkOutput(name, e);
    endtask

    vec_t vecs[16];

    initial begin
        stim_t t, d, sc, r;

        t = '0; t.rst = 1'b1;
        vecs[0] = '{t, mkExp(0, 0, 0, 0, 0, 0)};
        vecs[1] = '{aluOp(3, 32'h1234_5678), mkExp(1, 1, 3, 32'h1234_5678, 0, 1)};
        t = aluOp(5, 32'hDEAD); t.memtoregm = 1; t.ldsizem = 2'b10; t.ldsignm = 1;
        t.addrlom = 2; t.rdm = 32'h0080_0000;
        vecs[2] = '{t, mkExp(1, 1, 5, 32'hFFFF_FF80, 0, 2)};
        t.ldsignm = 0;
        vecs[3] = '{t, mkExp(1, 1, 5, 32'h0000_0080, 0, 3)};
        vecs[4] = '{aluOp(0, 32'h55), mkExp(1, 0, 0, 32'h55, 0, 4)};
        t = aluOp(31, 32'h99); t.jumplinkm = 1; t.memtoregm = 1; t.pcplus4m = 32'h400;
        t.rdm = 32'h1122_3344; t.ldsizem = 2'b11;
        vecs[5] = '{t, mkExp(1, 1, 31, 32'h400, 0, 5)};
        t = aluOp(7, 0); t.memtoregm = 1; t.ldsizem = 2'b01; t.addrlom = 3;
        t.rdm = 32'h8001_7FFF; t.ldsignm = 1;
        vecs[6] = '{t, mkExp(1, 1, 7, 32'hFFFF_8001, 0, 6)};
        t = aluOp(8, 0); t.regwritem = 0; t.memtoregm = 1; t.ldsizem = 2'b00;
        t.addrlom = 1; t.rdm = 32'hCAFE_BABE;
        vecs[7] = '{t, mkExp(1, 0, 8, 32'hCAFE_BABE, 0, 7)};
        t = '0;
        vecs[8] = '{t, mkExp(0, 0, 0, 0, 0, 7)};
        t.rst = 1'b1;
        vecs[9] = '{t, mkExp(0, 0, 0, 0, 0, 0)};
        vecs[10] = '{aluOp(4, 32'hAAAA), mkExp(1, 1, 4, 32'hAAAA, 0, 1)};
        t = aluOp(9, 32'hBBBB); t.stall = 1;
        vecs[11] = '{t, mkExp(1, 1, 4, 32'hAAAA, 0, 1)};
        vecs[12] = '{t, mkExp(1, 1, 4, 32'hAAAA, 0, 1)};
        vecs[13] = '{t, mkExp(1, 1, 4, 32'hAAAA, 0, 1)};
        t.flush = 1;
        vecs[14] = '{t, mkExp(0, 0, 0, 0, 0, 1)};
        vecs[15] = '{aluOp(9, 32'hBBBB), mkExp(1, 1, 9, 32'hBBBB, 0, 2)};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end

        // Syscall halt, held register, resume under stall, ignored resume in RUN.
        sc = aluOp(2, 32'h5C); sc.syscallm = 1;
        d  = aluOp(6, 32'hD0);
        step("sys_capture", sc, mkExp(1, 1, 2, 32'h5C, 0, 3));
        t = d; t.stall = 1;
        step("sys_halt", t, mkExp(1, 0, 2, 32'h5C, 1, 3));
        step("sys_hold_nostall", d, mkExp(1, 0, 2, 32'h5C, 1, 3));
        step("sys_hold_stall", t, mkExp(1, 0, 2, 32'h5C, 1, 3));
        t.resume = 1;
        step("sys_resume_stall", t, mkExp(1, 1, 2, 32'h5C, 0, 3));
        t.resume = 0;
        step("sys_no_rehalt", t, mkExp(1, 1, 2, 32'h5C, 0, 3));
        t = d; t.resume = 1;
        step("resume_in_run", t, mkExp(1, 1, 6, 32'hD0, 0, 4));
        step("after_run_resume", '0, mkExp(0, 0, 0, 0, 0, 4));

        // Flush while halted bubbles WB but keeps HALT; reset clears everything.
        step("sys2_capture", sc, mkExp(1, 1, 2, 32'h5C, 0, 5));
        t = '0; t.stall = 1;
        step("sys2_halt", t, mkExp(1, 0, 2, 32'h5C, 1, 5));
        t = d; t.flush = 1;
        step("halt_flush", t, mkExp(0, 0, 0, 0, 1, 5));
        step("halt_stays", d, mkExp(0, 0, 0, 0, 1, 5));
        t = d; t.rst = 1; t.stall = 1;
        step("halt_reset", t, mkExp(0, 0, 0, 0, 0, 0));
        step("post_reset", d, mkExp(1, 1, 6, 32'hD0, 0, 1));

        // Counter wrap with a 4-bit counter.
        t = '0; t.rst = 1;
        step("wrap_reset", t, mkExp(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            step($sformatf("wrap%0d", i), aluOp(1, 32'(i)),
                 mkExp(1, 1, 1, 32'(i), 0, 4'((i + 1) % 16)));
        end

        // Randomized traffic against the model.
        t = '0; t.rst = 1;
        applyStimulus(t);
        for (int i = 0; i < 400; i++) begin
            r = '0;
            r.rst       = ($urandom_range(0, 49) == 0);
            r.stall     = ($urandom_range(0, 4) == 0);
            r.flush     = ($urandom_range(0, 7) == 0);
            r.validm    = ($urandom_range(0, 3) != 0);
            r.regwritem = 1'($urandom);
            r.memtoregm = 1'($urandom);
            r.jumplinkm = ($urandom_range(0, 5) == 0);
            r.syscallm  = ($urandom_range(0, 9) == 0);
            r.ldsignm   = 1'($urandom);
            r.ldsizem   = 2'($urandom);
            r.addrlom   = 2'($urandom);
            r.rdm       = $urandom;
            r.aluoutm   = $urandom;
            r.pcplus4m  = $urandom;
            r.writeregm = 5'($urandom_range(0, 31));
            r.resume    = ($urandom_range(0, 3) == 0);
            applyStimulus(r);
            checkOutput($sformatf("rand%0d", i), modelExpect());
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
